// File: rtl/dram_port_arbiter.sv
// Shares one DRAM read-address / read-data / write port triple among N_CH clients.
// Reads and writes are arbitrated round-robin, and read tags are kept in issue order to route returned lines.
module dram_port_arbiter #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned GBW         = 32,
    parameter int unsigned DBW         = 8,
    parameter int unsigned CSIZE       = 4,
    parameter int unsigned OUTSTANDING = 8
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic [N_CH-1:0]                        ch_ra_rdy,
    output logic [N_CH-1:0]                        ch_ra_ack,
    input  logic [N_CH-1:0][GBW-1:0]               i_ch_ra,
    output logic [N_CH-1:0]                        ch_rd_rdy,
    input  logic [N_CH-1:0]                        ch_rd_ack,
    output logic [CSIZE-1:0][DBW-1:0]              o_ch_rd,
    input  logic [N_CH-1:0]                        ch_w_rdy,
    output logic [N_CH-1:0]                        ch_w_ack,
    input  logic [N_CH-1:0][GBW-1:0]               i_ch_wa,
    input  logic [N_CH-1:0][CSIZE-1:0][DBW-1:0]    i_ch_wd,
    input  logic [N_CH-1:0][CSIZE-1:0]             i_ch_w_mask,
    output logic                                   dramra_rdy,
    input  logic                                   dramra_ack,
    output logic [GBW-1:0]                         o_dramra,
    input  logic                                   dramrd_rdy,
    output logic                                   dramrd_ack,
    input  logic [CSIZE-1:0][DBW-1:0]              i_dramrd,
    output logic                                   dramw_rdy,
    input  logic                                   dramw_ack,
    output logic [GBW-1:0]                         o_dramwa,
    output logic [CSIZE-1:0][DBW-1:0]              o_dramwd,
    output logic [CSIZE-1:0]                       o_dramw_mask,
    output logic [$clog2(OUTSTANDING+1)-1:0]       o_outstanding,
    output logic                                   o_err
);

    localparam int unsigned CH_BW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned PW    = $clog2(OUTSTANDING);
    localparam int unsigned OCW   = $clog2(OUTSTANDING + 1);

    typedef logic [CH_BW-1:0] ch_t;

    function automatic ch_t rr_pick(input logic [N_CH-1:0] req, input ch_t base);
        ch_t  pick;
        ch_t  idx;
        logic found;
        pick  = base;
        found = 1'b0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            idx = ch_t'((32'(base) + k) % N_CH);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic ch_t next_rr(input ch_t s);
        return (32'(s) == N_CH - 1) ? '0 : ch_t'(s + 1'b1);
    endfunction

    function automatic logic [N_CH-1:0] onehot(input ch_t s);
        logic [N_CH-1:0] oh;
        oh    = '0;
        oh[s] = 1'b1;
        return oh;
    endfunction

    ch_t              rr_ra_r, lock_sel_ra_r, sel_ra;
    ch_t              rr_w_r, lock_sel_w_r, sel_w;
    logic             lock_ra_r, lock_w_r;
    ch_t              tag_mem [OUTSTANDING];
    logic [PW-1:0]    wr_ptr_r, rd_ptr_r;
    logic [OCW-1:0]   count_r;
    logic             fifo_full, fifo_empty, ra_push, rd_valid, w_take;
    ch_t              head;

    assign fifo_full  = (count_r == OCW'(OUTSTANDING));
    assign fifo_empty = (count_r == '0);
    assign head       = tag_mem[rd_ptr_r];

    // rdy/ack outputs are forced low while reset is held so a mid-transfer reset idles every port at once
    always_comb begin
        sel_ra     = lock_ra_r ? lock_sel_ra_r : rr_pick(ch_ra_rdy, rr_ra_r);
        dramra_rdy = !i_rst && (|ch_ra_rdy) && !fifo_full;
        ra_push    = dramra_rdy && dramra_ack;
        ch_ra_ack  = ra_push ? onehot(sel_ra) : '0;
        o_dramra   = i_ch_ra[sel_ra];

        rd_valid   = !i_rst && dramrd_rdy && !fifo_empty;
        ch_rd_rdy  = rd_valid ? onehot(head) : '0;
        dramrd_ack = rd_valid && ch_rd_ack[head];
        o_ch_rd    = i_dramrd;

        sel_w        = lock_w_r ? lock_sel_w_r : rr_pick(ch_w_rdy, rr_w_r);
        dramw_rdy    = !i_rst && (|ch_w_rdy);
        w_take       = dramw_rdy && dramw_ack;
        ch_w_ack     = w_take ? onehot(sel_w) : '0;
        o_dramwa     = i_ch_wa[sel_w];
        o_dramwd     = i_ch_wd[sel_w];
        o_dramw_mask = i_ch_w_mask[sel_w];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_ra_r       <= '0;
            lock_ra_r     <= 1'b0;
            lock_sel_ra_r <= '0;
        end else if (ra_push) begin
            rr_ra_r   <= next_rr(sel_ra);
            lock_ra_r <= 1'b0;
        end else if (dramra_rdy) begin
            lock_ra_r     <= 1'b1;
            lock_sel_ra_r <= sel_ra;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_w_r       <= '0;
            lock_w_r     <= 1'b0;
            lock_sel_w_r <= '0;
        end else if (w_take) begin
            rr_w_r   <= next_rr(sel_w);
            lock_w_r <= 1'b0;
        end else if (dramw_rdy) begin
            lock_w_r     <= 1'b1;
            lock_sel_w_r <= sel_w;
        end
    end

    always_ff @(posedge i_clk) begin
        if (ra_push) tag_mem[wr_ptr_r] <= sel_ra;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            o_err    <= 1'b0;
        end else begin
            if (ra_push)    wr_ptr_r <= wr_ptr_r + 1'b1;
            if (dramrd_ack) rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({ra_push, dramrd_ack})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
            if (dramrd_rdy && fifo_empty) o_err <= 1'b1;
        end
    end

    assign o_outstanding = count_r;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed-vector bench for dram_port_arbiter: table of per-cycle stimulus/expectations plus hand sequences.
module tb_dram_port_arbiter;

    localparam int unsigned N_CH = 4, GBW = 32, DBW = 8, CSIZE = 4, OUTSTANDING = 8;

    logic                                i_clk, i_rst;
    logic [N_CH-1:0]                     ch_ra_rdy, ch_ra_ack, ch_rd_rdy, ch_rd_ack, ch_w_rdy, ch_w_ack;
    logic [N_CH-1:0][GBW-1:0]            i_ch_ra, i_ch_wa;
    logic [N_CH-1:0][CSIZE-1:0][DBW-1:0] i_ch_wd;
    logic [N_CH-1:0][CSIZE-1:0]          i_ch_w_mask;
    logic [CSIZE-1:0][DBW-1:0]           o_ch_rd, i_dramrd, o_dramwd;
    logic                                dramra_rdy, dramra_ack, dramrd_rdy, dramrd_ack, dramw_rdy, dramw_ack;
    logic [GBW-1:0]                      o_dramra, o_dramwa;
    logic [CSIZE-1:0]                    o_dramw_mask;
    logic [3:0]                          o_outstanding;
    logic                                o_err;

    dram_port_arbiter #(.N_CH(N_CH), .GBW(GBW), .DBW(DBW), .CSIZE(CSIZE), .OUTSTANDING(OUTSTANDING)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .ch_ra_rdy(ch_ra_rdy), .ch_ra_ack(ch_ra_ack), .i_ch_ra(i_ch_ra),
        .ch_rd_rdy(ch_rd_rdy), .ch_rd_ack(ch_rd_ack), .o_ch_rd(o_ch_rd),
        .ch_w_rdy(ch_w_rdy), .ch_w_ack(ch_w_ack), .i_ch_wa(i_ch_wa), .i_ch_wd(i_ch_wd),
        .i_ch_w_mask(i_ch_w_mask),
        .dramra_rdy(dramra_rdy), .dramra_ack(dramra_ack), .o_dramra(o_dramra),
        .dramrd_rdy(dramrd_rdy), .dramrd_ack(dramrd_ack), .i_dramrd(i_dramrd),
        .dramw_rdy(dramw_rdy), .dramw_ack(dramw_ack),
        .o_dramwa(o_dramwa), .o_dramwd(o_dramwd), .o_dramw_mask(o_dramw_mask),
        .o_outstanding(o_outstanding), .o_err(o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]  ra_rdy;   logic ra_ack;
        logic [3:0]  w_rdy;    logic w_ack;
        logic        rd_rdy;   logic [3:0] rd_ack;
        logic [3:0]  e_ra_ack; logic e_ra_rdy; logic [31:0] e_ra;
        logic [3:0]  e_w_ack;  logic e_w_rdy;  logic [31:0] e_wa;
        logic [3:0]  e_rd_rdy; logic e_rd_ack;
        logic [3:0]  e_outst;  logic e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic vec_t mk(
        input logic [3:0] ra_rdy, input logic ra_ack, input logic [3:0] w_rdy, input logic w_ack,
        input logic rd_rdy, input logic [3:0] rd_ack,
        input logic [3:0] e_ra_ack, input logic e_ra_rdy, input logic [31:0] e_ra,
        input logic [3:0] e_w_ack, input logic e_w_rdy, input logic [31:0] e_wa,
        input logic [3:0] e_rd_rdy, input logic e_rd_ack, input logic [3:0] e_outst, input logic e_err);
        vec_t v;
        v.ra_rdy = ra_rdy;     v.ra_ack = ra_ack;     v.w_rdy = w_rdy;   v.w_ack = w_ack;
        v.rd_rdy = rd_rdy;     v.rd_ack = rd_ack;
        v.e_ra_ack = e_ra_ack; v.e_ra_rdy = e_ra_rdy; v.e_ra = e_ra;
        v.e_w_ack = e_w_ack;   v.e_w_rdy = e_w_rdy;   v.e_wa = e_wa;
        v.e_rd_rdy = e_rd_rdy; v.e_rd_ack = e_rd_ack; v.e_outst = e_outst; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic [3:0] ra_rdy, input logic ra_ack, input logic [3:0] w_rdy,
                         input logic w_ack, input logic rd_rdy, input logic [3:0] rd_ack);
        ch_ra_rdy = ra_rdy; dramra_ack = ra_ack; ch_w_rdy = w_rdy; dramw_ack = w_ack;
        dramrd_rdy = rd_rdy; ch_rd_ack = rd_ack;
    endtask

    initial begin
        i_rst = 1'b1;
        drive(4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
        i_ch_ra[0] = 32'h040; i_ch_ra[1] = 32'h080; i_ch_ra[2] = 32'h100; i_ch_ra[3] = 32'h180;
        for (int c = 0; c < 4; c++) begin
            i_ch_wa[c]     = 32'h100 * (c + 1);
            i_ch_w_mask[c] = 4'(c + 5);
            for (int w = 0; w < 4; w++) i_ch_wd[c][w] = 8'(16 * c + w);
        end
        i_ch_w_mask[1] = 4'hF;
        i_dramrd = 32'hA5B6_C7D8;

        // round-robin fairness, then draining the five tags in grant order
        vecs.push_back(mk(4'hF,1,0,0,0,0, 4'h1,1,32'h040, 0,0,0, 0,0,0,0));
        vecs.push_back(mk(4'hF,1,0,0,0,0, 4'h2,1,32'h080, 0,0,0, 0,0,1,0));
        vecs.push_back(mk(4'hF,1,0,0,0,0, 4'h4,1,32'h100, 0,0,0, 0,0,2,0));
        vecs.push_back(mk(4'hF,1,0,0,0,0, 4'h8,1,32'h180, 0,0,0, 0,0,3,0));
        vecs.push_back(mk(4'hF,1,0,0,0,0, 4'h1,1,32'h040, 0,0,0, 0,0,4,0));
        vecs.push_back(mk(0,0,0,0,1,4'hF, 0,0,0, 0,0,0, 4'h1,1,5,0));
        vecs.push_back(mk(0,0,0,0,1,4'hF, 0,0,0, 0,0,0, 4'h2,1,4,0));
        vecs.push_back(mk(0,0,0,0,1,4'hF, 0,0,0, 0,0,0, 4'h4,1,3,0));
        vecs.push_back(mk(0,0,0,0,1,4'hF, 0,0,0, 0,0,0, 4'h8,1,2,0));
        vecs.push_back(mk(0,0,0,0,1,4'hF, 0,0,0, 0,0,0, 4'h1,1,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,    0,0,0, 0,0,0, 0,0,0,0));
        // single read from ch2
        vecs.push_back(mk(4'h4,1,0,0,0,0, 4'h4,1,32'h100, 0,0,0, 0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,    0,0,0, 0,0,0, 0,0,1,0));
        vecs.push_back(mk(0,0,0,0,1,0,    0,0,0, 0,0,0, 4'h4,0,1,0));
        vecs.push_back(mk(0,0,0,0,1,4'h4, 0,0,0, 0,0,0, 4'h4,1,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,    0,0,0, 0,0,0, 0,0,0,0));
        // ch3 read moves the pointer to 0, then ch3 locks the port against ch0 for three stalls
        vecs.push_back(mk(4'h8,1,0,0,0,0, 4'h8,1,32'h180, 0,0,0, 0,0,0,0));
        vecs.push_back(mk(4'h8,0,0,0,0,0, 4'h0,1,32'h180, 0,0,0, 0,0,1,0));
        vecs.push_back(mk(4'h9,0,0,0,0,0, 4'h0,1,32'h180, 0,0,0, 0,0,1,0));
        vecs.push_back(mk(4'h9,0,0,0,0,0, 4'h0,1,32'h180, 0,0,0, 0,0,1,0));
        vecs.push_back(mk(4'h9,1,0,0,0,0, 4'h8,1,32'h180, 0,0,0, 0,0,1,0));
        vecs.push_back(mk(4'h1,1,0,0,0,0, 4'h1,1,32'h040, 0,0,0, 0,0,2,0));
        vecs.push_back(mk(0,0,0,0,1,4'hF, 0,0,0, 0,0,0, 4'h8,1,3,0));
        vecs.push_back(mk(0,0,0,0,1,4'hF, 0,0,0, 0,0,0, 4'h8,1,2,0));
        vecs.push_back(mk(0,0,0,0,1,4'hF, 0,0,0, 0,0,0, 4'h1,1,1,0));
        // concurrent ch0 read and ch1 write
        vecs.push_back(mk(4'h1,1,4'h2,1,0,0, 4'h1,1,32'h040, 4'h2,1,32'h200, 0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,4'h1,    0,0,0,          0,0,0,          4'h1,1,1,0));
        // write round-robin and write lock
        vecs.push_back(mk(0,0,4'hF,1,0,0, 0,0,0, 4'h4,1,32'h300, 0,0,0,0));
        vecs.push_back(mk(0,0,4'hF,1,0,0, 0,0,0, 4'h8,1,32'h400, 0,0,0,0));
        vecs.push_back(mk(0,0,4'hF,1,0,0, 0,0,0, 4'h1,1,32'h100, 0,0,0,0));
        vecs.push_back(mk(0,0,4'h4,0,0,0, 0,0,0, 4'h0,1,32'h300, 0,0,0,0));
        vecs.push_back(mk(0,0,4'h6,0,0,0, 0,0,0, 4'h0,1,32'h300, 0,0,0,0));
        vecs.push_back(mk(0,0,4'h6,1,0,0, 0,0,0, 4'h4,1,32'h300, 0,0,0,0));
        vecs.push_back(mk(0,0,4'h2,1,0,0, 0,0,0, 4'h2,1,32'h200, 0,0,0,0));

        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("rst ch_ra_ack",  32'(ch_ra_ack), 0);
        check("rst ch_w_ack",   32'(ch_w_ack), 0);
        check("rst ch_rd_rdy",  32'(ch_rd_rdy), 0);
        check("rst dramra_rdy", 32'(dramra_rdy), 0);
        check("rst dramw_rdy",  32'(dramw_rdy), 0);
        check("rst dramrd_ack", 32'(dramrd_ack), 0);
        check("rst o_dramra",   o_dramra, 32'h040);
        check("rst o_dramwa",   o_dramwa, 32'h100);
        check("rst w_mask",     32'(o_dramw_mask), 32'h5);
        check("rst outst",      32'(o_outstanding), 0);
        check("rst err",        32'(o_err), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge i_clk);
            drive(vecs[i].ra_rdy, vecs[i].ra_ack, vecs[i].w_rdy, vecs[i].w_ack, vecs[i].rd_rdy, vecs[i].rd_ack);
            #1;
            check($sformatf("v%0d ch_ra_ack", i),  32'(ch_ra_ack),  32'(vecs[i].e_ra_ack));
            check($sformatf("v%0d dramra_rdy", i), 32'(dramra_rdy), 32'(vecs[i].e_ra_rdy));
            if (vecs[i].e_ra_rdy) check($sformatf("v%0d o_dramra", i), o_dramra, vecs[i].e_ra);
            check($sformatf("v%0d ch_w_ack", i),   32'(ch_w_ack),   32'(vecs[i].e_w_ack));
            check($sformatf("v%0d dramw_rdy", i),  32'(dramw_rdy),  32'(vecs[i].e_w_rdy));
            if (vecs[i].e_w_rdy) check($sformatf("v%0d o_dramwa", i), o_dramwa, vecs[i].e_wa);
            check($sformatf("v%0d ch_rd_rdy", i),  32'(ch_rd_rdy),  32'(vecs[i].e_rd_rdy));
            check($sformatf("v%0d dramrd_ack", i), 32'(dramrd_ack), 32'(vecs[i].e_rd_ack));
            check($sformatf("v%0d outst", i),      32'(o_outstanding), 32'(vecs[i].e_outst));
            check($sformatf("v%0d err", i),        32'(o_err),      32'(vecs[i].e_err));
        end

        // FIFO full: eight reads from ch1 with no returns
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            drive(4'h2, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0);
            #1;
            check($sformatf("fill%0d ch_ra_ack", i), 32'(ch_ra_ack), 32'h2);
            check($sformatf("fill%0d outst", i), 32'(o_outstanding), 32'(i));
        end
        @(negedge i_clk);
        drive(4'h2, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
        #1;
        check("full dramra_rdy", 32'(dramra_rdy), 0);
        check("full outst", 32'(o_outstanding), 8);
        @(negedge i_clk);
        drive(4'h2, 1'b0, 4'h0, 1'b0, 1'b1, 4'h2);
        #1;
        check("full+pop dramra_rdy", 32'(dramra_rdy), 0);
        check("full+pop dramrd_ack", 32'(dramrd_ack), 1);
        check("full+pop ch_rd_rdy", 32'(ch_rd_rdy), 32'h2);
        check("full+pop o_ch_rd", o_ch_rd, 32'hA5B6_C7D8);
        @(negedge i_clk);
        drive(4'h2, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0);
        #1;
        check("after pop dramra_rdy", 32'(dramra_rdy), 1);
        check("after pop ch_ra_ack", 32'(ch_ra_ack), 32'h2);
        check("after pop outst", 32'(o_outstanding), 7);
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            drive(4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h2);
            #1;
            check($sformatf("drain%0d dramrd_ack", i), 32'(dramrd_ack), 1);
            check($sformatf("drain%0d outst", i), 32'(o_outstanding), 32'(8 - i));
        end

        // write payload from ch1 held stable across a stall
        @(negedge i_clk);
        drive(4'h0, 1'b0, 4'h2, 1'b0, 1'b0, 4'h0);
        #1;
        check("wr o_dramwa", o_dramwa, 32'h200);
        check("wr mask", 32'(o_dramw_mask), 32'hF);
        check("wr data", o_dramwd, 32'h1312_1110);
        check("wr stall ack", 32'(ch_w_ack), 0);
        @(negedge i_clk);
        drive(4'h0, 1'b0, 4'h2, 1'b1, 1'b0, 4'h0);
        #1;
        check("wr ack", 32'(ch_w_ack), 32'h2);
        check("wr outst", 32'(o_outstanding), 0);

        // protocol error: return presented while nothing is outstanding
        @(negedge i_clk);
        drive(4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'hF);
        #1;
        check("err dramrd_ack", 32'(dramrd_ack), 0);
        check("err ch_rd_rdy", 32'(ch_rd_rdy), 0);
        check("err before edge", 32'(o_err), 0);
        @(negedge i_clk);
        drive(4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
        #1;
        check("err sticky", 32'(o_err), 1);

        // reset mid-burst
        repeat (2) begin
            @(negedge i_clk);
            drive(4'hF, 1'b1, 4'hF, 1'b1, 1'b0, 4'h0);
        end
        @(negedge i_clk);
        #1;
        check("burst outst", 32'(o_outstanding), 2);
        #1;
        i_rst = 1'b1;
        #1;
        check("mid-rst dramra_rdy", 32'(dramra_rdy), 0);
        check("mid-rst dramw_rdy", 32'(dramw_rdy), 0);
        check("mid-rst ch_ra_ack", 32'(ch_ra_ack), 0);
        check("mid-rst ch_w_ack", 32'(ch_w_ack), 0);
        check("mid-rst outst", 32'(o_outstanding), 0);
        check("mid-rst err", 32'(o_err), 0);
        drive(4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        #1;
        check("post-rst outst", 32'(o_outstanding), 0);
        check("post-rst err", 32'(o_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Multi-channel DRAM front end for the next-generation top, where N_CH tile accumulate units share one DRAM read-address/read-data/write port triple.
- Arbitrates read-address and write requests round-robin.
- Tracks outstanding reads in an in-order tag FIFO and routes each returned read line to the channel that issued it.
- All ports use the rdyack handshake: sender holds rdy and payload stable until ack; ack is asserted only in a cycle where rdy is high.

Parameters:
- N_CH, 4, number of client channels (>=1); CH_BW = max(1, $clog2(N_CH)).
- GBW, TauCfg::GLOBAL_ADDR_BW, DRAM address width.
- DBW, TauCfg::DATA_BW, width of one data word.
- CSIZE, TauCfg::CACHE_SIZE, words per DRAM line.
- OUTSTANDING, 8, read tag FIFO depth (power of 2, >=2).

Ports:
- i_clk in 1: clock.
- i_rst in 1: asynchronous, active-high reset.
- ch_ra_rdy in N_CH, ch_ra_ack out N_CH: per-channel read-address handshake.
- i_ch_ra in [N_CH][GBW]: per-channel read addresses.
- ch_rd_rdy out N_CH, ch_rd_ack in N_CH: per-channel read-data return handshake.
- o_ch_rd out [CSIZE][DBW]: read line, broadcast to all channels.
- ch_w_rdy in N_CH, ch_w_ack out N_CH: per-channel write handshake.
- i_ch_wa in [N_CH][GBW]: write addresses.
- i_ch_wd in [N_CH][CSIZE][DBW]: write data.
- i_ch_w_mask in [N_CH][CSIZE]: write masks.
- dramra_rdy out 1, dramra_ack in 1, o_dramra out GBW: DRAM read-address port.
- dramrd_rdy in 1, dramrd_ack out 1, i_dramrd in [CSIZE][DBW]: DRAM read-data port.
- dramw_rdy out 1, dramw_ack in 1: DRAM write handshake.
- o_dramwa out GBW, o_dramwd out [CSIZE][DBW], o_dramw_mask out CSIZE: DRAM write payload.
- o_outstanding out $clog2(OUTSTANDING+1): tag FIFO occupancy.
- o_err out 1: sticky protocol error.

Behaviour:
- Reset (async, i_rst=1): rr pointers and lock registers clear to 0; FIFO empty; o_outstanding=0; o_err=0.
  - All outputs are combinational from this state, so every rdy/ack output is 0. o_dramra, o_dramwa, o_dramwd and o_dramw_mask show channel 0's inputs.
- Read-address arbiter, unlocked:
  - sel = first channel c with ch_ra_rdy[c], scanning rr_ra_r, rr_ra_r+1, … mod N_CH.
  - dramra_rdy = |ch_ra_rdy && !fifo_full. o_dramra = i_ch_ra[sel]. Zero-cycle forwarding.
- Read lock:
  - If dramra_rdy=1 and dramra_ack=0, register lock_ra_r=1 and lock_sel_ra_r=sel.
  - While locked, sel = lock_sel_ra_r regardless of other requests. This keeps the DRAM-side rdy/payload stable.
  - fifo_full cannot rise while locked, because only reads push.
- Read accept, on dramra_ack:
  - ch_ra_ack[sel]=1 in the same cycle.
  - Push sel to the tag FIFO.
  - rr_ra_r <= sel+1, wrapping N_CH-1 to 0.
  - Clear the lock.
- Read return:
  - h = FIFO head tag.
  - ch_rd_rdy[h] = dramrd_rdy && !fifo_empty; all other ch_rd_rdy bits = 0.
  - o_ch_rd = i_dramrd.
  - dramrd_ack = ch_rd_ack[h] && !fifo_empty.
  - Pop on dramrd_ack.
  - DRAM returns strictly in issue order.
- Simultaneous push and pop: occupancy unchanged; pointers both advance.
  - Full gating uses the registered full flag only. A push is refused at OUTSTANDING even when a pop occurs the same cycle, so there is no combinational ack-to-rdy path.
- Error:
  - dramrd_rdy=1 with the FIFO empty sets o_err=1 (sticky until reset).
  - dramrd_ack stays 0 in that case.
  - ch_rd_ack for a channel whose ch_rd_rdy is 0 is ignored.
- Write arbiter:
  - Independent rr_w_r, lock_w_r and lock_sel_w_r with identical round-robin/lock rules.
  - dramw_rdy = |ch_w_rdy; payload muxed from the selected channel.
  - ch_w_ack[sel] = dramw_ack.
  - No FIFO; writes are never gated by read occupancy.
- Ordering:
  - No read/write ordering is enforced across channels or between a channel's reads and writes. Clients own hazards.
  - Per-channel reads return in issue order.
- N_CH=1: arbiters degenerate; rr stays 0; behaviour is otherwise identical.
- Reset mid-transfer: in-flight FIFO tags are discarded. The DRAM model must be reset together with this block.

Test Plan:
- Single read: ch2 requests address 0x100 and DRAM acks in the same cycle → o_dramra=0x100; ch_ra_ack=4'b0100 that cycle; o_outstanding=1. The data line is then presented → ch_rd_rdy=4'b0100; after ch2 ack, o_outstanding=0.
- Round-robin fairness: all 4 channels hold ra_rdy and DRAM acks every cycle → grant order 0,1,2,3,0; return data tags the same order.
- Lock stability: ch3 requests; DRAM stalls 3 cycles; ch0 asserts rdy in stall cycle 1 → o_dramra stays ch3's address, and ch3 is acked first. ch0 is granted next.
- FIFO full: OUTSTANDING=8 reads accepted with no returns → dramra_rdy=0 with 8 outstanding. A return plus ack in the next cycle → dramra_rdy=1 the following cycle.
- Concurrent read/write: ch1 write (mask 0x0F, addr 0x200) together with ch0 read → both DRAM ports active in the same cycle; ch_w_ack=4'b0010 and ch_ra_ack=4'b0001 independently.
- Error and reset: dramrd_rdy=1 with an empty FIFO → o_err=1 and dramrd_ack=0. Asserting i_rst mid-burst → all rdy/ack go to 0 immediately, with o_outstanding=0 and o_err=0.
